// File: rtl/ysyx_040066_clint_n.sv
// rtl/ysyx_040066_clint_n.sv - core-local interruptor: mtime, per-hart mtimecmp and msip
module ysyx_040066_clint_n #(
    parameter int          NHART    = 1,
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      addr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wmask,
    input  logic             rd_req,
    input  logic             wr_req,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             hit_q,
    output logic [63:0]      rdata,
    output logic             err,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip,
    output logic [63:0]      mtime_o,
    output logic             wr_clr
);
    localparam int          PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [11:0] NH12 = 12'(NHART);
    localparam logic [10:0] NH11 = 11'(NHART);

    logic [63:0]   mtime;
    logic [63:0]   mtime_nx;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;
    logic [63:0]   cmp [NHART];

    logic        hit, access, legal, wr, rd, tick;
    logic        is_msip, is_cmp, is_mtime;
    logic        msip_ok, cmp_ok, mtime_ok;
    logic [15:0] off;
    logic [11:0] msip_idx;
    logic [10:0] cmp_idx;
    logic [63:0] rd_val;
    logic        msip_bit, msip_en;

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] mask);
        logic [63:0] r;
        for (int b = 0; b < 8; b++)
            r[b*8 +: 8] = mask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    assign hit      = (addr[63:16] == BASE[63:16]);
    assign off      = addr[15:0];
    assign access   = (rd_req | wr_req) & hit;
    assign mem_rd   = rd_req & ~hit;
    assign mem_wr   = wr_req & ~hit;
    assign mtime_o  = mtime;

    assign is_msip  = (off[15:14] == 2'b00);
    assign is_cmp   = (off[15:14] == 2'b01);
    assign is_mtime = (off[15:3] == 13'h17FF);
    assign msip_idx = off[13:2];
    assign cmp_idx  = off[13:3];
    assign msip_ok  = is_msip & (msip_idx < NH12) & (off[1:0] == 2'b00);
    assign cmp_ok   = is_cmp & (cmp_idx < NH11) & (off[2:0] == 3'b000);
    assign mtime_ok = is_mtime & (off[2:0] == 3'b000);
    assign legal    = msip_ok | cmp_ok | mtime_ok;
    assign wr       = wr_req & hit & legal;
    assign rd       = rd_req & hit & legal;

    // msip occupies one 32-bit lane of the doubleword selected by addr[2]
    assign msip_bit = addr[2] ? wdata[32] : wdata[0];
    assign msip_en  = addr[2] ? wmask[4] : wmask[0];

    always_comb begin
        rd_val = 64'd0;
        for (int h = 0; h < NHART; h++) begin
            if (msip_ok && msip_idx == 12'(h))
                rd_val = addr[2] ? {31'd0, msip[h], 32'd0} : {63'd0, msip[h]};
            if (cmp_ok && cmp_idx == 11'(h))
                rd_val = cmp[h];
        end
        if (mtime_ok)
            rd_val = mtime;
    end

    // A software write to mtime overrides the tick and restarts the prescaler
    always_comb begin
        tick     = (pre == PMAX);
        mtime_nx = mtime;
        pre_nx   = pre + 1'b1;
        if (wr && mtime_ok) begin
            mtime_nx = merge(mtime, wdata, wmask);
            pre_nx   = '0;
        end else if (tick) begin
            mtime_nx = mtime + 64'd1;
            pre_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime  <= 64'd0;
            pre    <= '0;
            msip   <= '0;
            mtip   <= '0;
            hit_q  <= 1'b0;
            rdata  <= 64'd0;
            err    <= 1'b0;
            wr_clr <= 1'b0;
            for (int h = 0; h < NHART; h++)
                cmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            mtime  <= mtime_nx;
            pre    <= pre_nx;
            hit_q  <= access;
            err    <= access & ~legal;
            rdata  <= rd ? rd_val : 64'd0;
            wr_clr <= wr & cmp_ok;
            for (int h = 0; h < NHART; h++) begin
                mtip[h] <= (mtime >= cmp[h]);
                if (wr && msip_ok && msip_idx == 12'(h) && msip_en)
                    msip[h] <= msip_bit;
                if (wr && cmp_ok && cmp_idx == 11'(h))
                    cmp[h] <= merge(cmp[h], wdata, wmask);
            end
        end
    end
endmodule
